// File: rtl/ps2_device_tx_if.sv
// Byte handshake into the PS/2 device transmitter.
// The source drives tx_data/tx_valid; the device answers with tx_ready.
interface ps2_device_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host transmitter: scan-code FIFO feeding an 11-bit
// frame serialiser with host-inhibit abort and inter-frame gap.
module ps2_device_tx #(
    parameter int CLK_HALF   = 4000,
    parameter int GAP_CYCLES = 10000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    ps2_device_tx_if.slave              tx,
    input  logic                        host_inhibit,
    output logic                        ps2_clk,
    output logic                        ps2_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXC = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;

    localparam logic [TW-1:0] HALF_END = TW'(CLK_HALF - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, CLK_HI, CLK_LO, GAP, HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [10:0]     frame_q, frame_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ps2_clk_q, ps2_clk_d;
    logic            ps2_data_q, ps2_data_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            push, pop, abort;

    assign push = tx.tx_valid && ready_q;
    assign abort = host_inhibit && (bit_cnt_q <= 4'd9);

    // The head byte is only retired once its stop bit completes, so an
    // aborted frame is simply reloaded from the FIFO head later.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !host_inhibit) state_d = LOAD;
            end
            LOAD: begin
                frame_d   = {1'b1, ~^mem_q[rd_ptr_q],
                             mem_q[rd_ptr_q], 1'b0};
                bit_cnt_d = '0;
                timer_d   = '0;
                state_d   = CLK_HI;
            end
            CLK_HI: begin
                if (abort) begin
                    state_d = HOLD;
                    timer_d = '0;
                end else if (timer_q == HALF_END) begin
                    state_d = CLK_LO;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CLK_LO: begin
                if (abort) begin
                    state_d = HOLD;
                    timer_d = '0;
                end else if (timer_q == HALF_END) begin
                    timer_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = GAP;
                        pop     = 1'b1;
                    end else begin
                        state_d   = CLK_HI;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        frame_d   = {1'b1, frame_q[10:1]};
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (timer_q == GAP_END) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (!host_inhibit) begin
                    state_d = GAP;
                    timer_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ps2_clk_d  = (state_d != CLK_LO);
        ps2_data_d = 1'b1;
        if (state_d == CLK_HI || state_d == CLK_LO) ps2_data_d = frame_d[0];
        busy_d     = (state_d != IDLE);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = tx.tx_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '1;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign tx.tx_ready = ready_q;
    assign ps2_clk     = ps2_clk_q;
    assign ps2_data    = ps2_data_q;
    assign busy        = busy_q;
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx: decodes frames off ps2_clk falls
// and matches them against the bytes the bench expects to be accepted.
module tb_ps2_device_tx;
    localparam int CLK_HALF   = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FIFO_DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       host_inhibit;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic [2:0] fifo_count;

    ps2_device_tx_if tx_bus ();

    ps2_device_tx #(
        .CLK_HALF  (CLK_HALF),
        .GAP_CYCLES(GAP_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .tx          (tx_bus),
        .host_inhibit(host_inhibit),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q [$];
    logic [10:0] rx_q  [$];

    logic        prev_clk = 1'b1;
    logic [10:0] mon_bits = '0;
    int          mon_idx  = 0;
    int          hi_run   = 0;
    int          fall_cnt = 0;

    // Host-side receiver: samples data on every ps2_clk fall; a long
    // high stretch means any partial frame was abandoned.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_idx  = 0;
            hi_run   = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk) begin
                mon_bits[mon_idx] = ps2_data;
                mon_idx++;
                fall_cnt++;
                if (mon_idx == 11) begin
                    rx_q.push_back(mon_bits);
                    mon_idx = 0;
                end
            end
            if (ps2_clk) hi_run++;
            else hi_run = 0;
            if (hi_run > CLK_HALF + 2) mon_idx = 0;
            prev_clk = ps2_clk;
        end
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic put(input logic [7:0] b);
        tx_bus.tx_valid = 1'b1;
        tx_bus.tx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic tx_idle();
        tx_bus.tx_valid = 1'b0;
        tx_bus.tx_data  = '0;
    endtask

    task automatic wait_frames(input int n, input int limit, output bit ok);
        int k;
        k = 0;
        while (rx_q.size() < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        host_inhibit = 1'b0;
        tx_idle();
        repeat (3) @(negedge clk);
        total++;
        if (ps2_clk !== 1'b1) begin
            bad++;
            $display("FAIL rst_clk got=%b exp=1", ps2_clk);
        end
        total++;
        if (ps2_data !== 1'b1) begin
            bad++;
            $display("FAIL rst_data got=%b exp=1", ps2_data);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        total++;
        if (fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL rst_count got=%0d exp=0", fifo_count);
        end
        total++;
        if (tx_bus.tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready got=%b exp=1", tx_bus.tx_ready);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int k;
        int n;
        bit ok;
        logic [10:0] got;
        @(posedge clk);
        #1;
        put(8'h1D);
        exp_q.push_back(8'h1D);
        tx_idle();
        // Start bit is visible from the second edge after the push edge.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ps2_data !== 1'b0 && k < 20);
        total++;
        if (k != 3) begin
            bad++;
            $display("FAIL start_latency got=%0d exp=3", k);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 300);
        total++;
        if (n != 11 * 2 * CLK_HALF + GAP_CYCLES) begin
            bad++;
            $display("FAIL busy_len got=%0d exp=%0d", n,
                     11 * 2 * CLK_HALF + GAP_CYCLES);
        end
        wait_frames(1, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_timeout got=%0d exp=1", rx_q.size());
        end else begin
            got = rx_q.pop_front();
            total++;
            if (got !== 11'b11000111010) begin
                bad++;
                $display("FAIL bits_1d got=%b exp=%b", got, 11'b11000111010);
            end
            total++;
            if (got !== frame_of(exp_q.pop_front())) begin
                bad++;
                $display("FAIL sb_single got=%b", got);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int run;
        int k;
        bit ok;
        logic [10:0] got;
        logic [7:0] e;
        @(posedge clk);
        #1;
        put(8'hF0);
        put(8'h1D);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1D);
        tx_idle();
        wait_frames(1, 200, ok);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ps2_clk !== 1'b1 && k < 20);
        // Gap cycles plus the IDLE and LOAD cycles before the next start bit.
        run = 0;
        while (ps2_clk === 1'b1 && ps2_data === 1'b1 && run < 100) begin
            run++;
            @(negedge clk);
        end
        total++;
        if (run != GAP_CYCLES + 2) begin
            bad++;
            $display("FAIL gap_run got=%0d exp=%0d", run, GAP_CYCLES + 2);
        end
        wait_frames(2, 200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_timeout got=%0d exp=2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                got = rx_q.pop_front();
                e   = exp_q.pop_front();
                total++;
                if (got !== frame_of(e)) begin
                    bad++;
                    $display("FAIL sb_b2b%0d got=%b exp=%b", i, got,
                             frame_of(e));
                end
            end
        end
        exp_q.delete();
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [10:0] got;
        logic [7:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            put(8'h30 + 8'(i));
            exp_q.push_back(8'h30 + 8'(i));
        end
        tx_bus.tx_valid = 1'b1;
        tx_bus.tx_data  = 8'h99;
        @(negedge clk);
        total++;
        if (fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_peak got=%0d exp=4", fifo_count);
        end
        total++;
        if (tx_bus.tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL ovf_ready got=%b exp=0", tx_bus.tx_ready);
        end
        @(posedge clk);
        #1;
        tx_idle();
        @(negedge clk);
        total++;
        if (fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_drop got=%0d exp=4", fifo_count);
        end
        wait_frames(4, 600, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovf_timeout got=%0d exp=4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                got = rx_q.pop_front();
                e   = exp_q.pop_front();
                total++;
                if (got !== frame_of(e)) begin
                    bad++;
                    $display("FAIL sb_ovf%0d got=%b exp=%b", i, got,
                             frame_of(e));
                end
            end
        end
        repeat (200) @(posedge clk);
        #1;
        total++;
        if (rx_q.size() != 0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL ovf_extra got=%0d/%0d exp=0/0", rx_q.size(),
                     fifo_count);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_inhibit();
        int k;
        int falls;
        bit ok;
        logic [10:0] got;
        @(posedge clk);
        #1;
        put(8'h1D);
        exp_q.push_back(8'h1D);
        tx_idle();
        k = 0;
        while (mon_idx != 5 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        host_inhibit = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
            bad++;
            $display("FAIL inh_release got=%b%b exp=11", ps2_clk, ps2_data);
        end
        total++;
        if (busy !== 1'b1 || fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL inh_hold got=%b/%0d exp=1/1", busy, fifo_count);
        end
        falls = fall_cnt;
        repeat (49) @(posedge clk);
        #1;
        total++;
        if (fall_cnt != falls || rx_q.size() != 0) begin
            bad++;
            $display("FAIL inh_quiet got=%0d/%0d exp=%0d/0", fall_cnt,
                     rx_q.size(), falls);
        end
        host_inhibit = 1'b0;
        wait_frames(1, 200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL inh_timeout got=%0d exp=1", rx_q.size());
        end else begin
            got = rx_q.pop_front();
            total++;
            if (got !== frame_of(exp_q.pop_front())) begin
                bad++;
                $display("FAIL sb_resend got=%b exp=%b", got,
                         frame_of(8'h1D));
            end
        end
        exp_q.delete();
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int k;
        int falls;
        @(posedge clk);
        #1;
        put(8'h1D);
        put(8'h55);
        tx_idle();
        k = 0;
        while (mon_idx != 6 && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
            bad++;
            $display("FAIL mrst_lines got=%b%b exp=11", ps2_clk, ps2_data);
        end
        total++;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mrst_state got=%0d/%b exp=0/0", fifo_count, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        falls = fall_cnt;
        repeat (150) @(posedge clk);
        #1;
        total++;
        if (fall_cnt != falls || rx_q.size() != 0) begin
            bad++;
            $display("FAIL mrst_quiet got=%0d/%0d exp=%0d/0", fall_cnt,
                     rx_q.size(), falls);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_parity();
        logic [7:0] bytes [3];
        logic       par   [3];
        bit ok;
        logic [10:0] got;
        logic [7:0] e;
        bytes[0] = 8'h00; par[0] = 1'b1;
        bytes[1] = 8'hFF; par[1] = 1'b1;
        bytes[2] = 8'h01; par[2] = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            put(bytes[i]);
            exp_q.push_back(bytes[i]);
        end
        tx_idle();
        wait_frames(3, 500, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL par_timeout got=%0d exp=3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = rx_q.pop_front();
                e   = exp_q.pop_front();
                total++;
                if (got[9] !== par[i]) begin
                    bad++;
                    $display("FAIL parity%0d got=%b exp=%b", i, got[9], par[i]);
                end
                total++;
                if (got !== frame_of(e)) begin
                    bad++;
                    $display("FAIL sb_par%0d got=%b exp=%b", i, got,
                             frame_of(e));
                end
            end
        end
        exp_q.delete();
    endtask

    initial begin
        rst_n           = 1'b0;
        host_inhibit    = 1'b0;
        tx_bus.tx_valid = 1'b0;
        tx_bus.tx_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_inhibit();
        test_reset_mid();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
